// File: rtl/l2_burst_responder_pkg.sv
// Shared LC-3b types for the L2 burst responder: word/line/beat types,
// the responder state encoding and a line-alignment helper.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l1_line;
    typedef logic [31:0]  lc3b_mem_beat;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP,
        DRAIN
    } l2_burst_state_t;

    // A 128-bit line spans 16 bytes, so the low 4 address bits are the offset.
    localparam lc3b_word LINE_ADDR_MASK = 16'hFFF0;

    // Clear the byte-offset bits so the burst always starts on a line boundary.
    function automatic lc3b_word line_align(input lc3b_word addr);
        return addr & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/l2_burst_responder_counter.sv
// Beat counter for one memory burst: cleared at acceptance, advanced on each
// completed beat, flags the final beat so the FSM knows when to leave BURST.
module burst_beat_counter #(
    parameter int NBEATS = 4,
    parameter int CNT_W  = $clog2(NBEATS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance; wrap happens naturally past the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (incr) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, dropped asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(NBEATS - 1));

endmodule

// File: rtl/l2_burst_responder.sv
// L2-side responder: accepts one line read/write from the L1 arbiter, runs it
// as an NBEATS-beat burst on the narrow memory port, then pulses l2_resp once.
// Every output is decoded from registers only, so no input reaches an output
// combinationally.
module l2_burst_responder
    import lc3b_types::*;
#(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  lc3b_word          l2_address,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [LINE_W-1:0] l2_wdata,
    output logic [LINE_W-1:0] l2_rdata,
    output logic              l2_resp,
    output lc3b_word          mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS);

    l2_burst_state_t   state_q,    state_d;
    logic              op_write_q, op_write_d;
    lc3b_word          addr_q,     addr_d;
    logic [LINE_W-1:0] wline_q,    wline_d;
    logic [LINE_W-1:0] rdata_q,    rdata_d;

    logic              cnt_clear;
    logic              cnt_incr;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;

    burst_beat_counter #(
        .NBEATS (NBEATS),
        .CNT_W  (CNT_W)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .incr    (cnt_incr),
        .cnt     (cnt),
        .last    (cnt_last)
    );

    // Next-state, request latching, read-beat assembly and output decode.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rdata_d     = rdata_q;
        cnt_clear   = 1'b0;
        cnt_incr    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        l2_resp     = 1'b0;
        mem_address = addr_q;
        mem_wdata   = '0;

        // Current write beat: slice cnt of the latched line, beat 0 in the LSBs.
        for (int b = 0; b < NBEATS; b++) begin
            if (cnt == CNT_W'(b)) begin
                mem_wdata = wline_q[b*BEAT_W +: BEAT_W];
            end
        end

        case (state_q)
            IDLE: begin
                // A simultaneous read and write is treated as a write.
                if (l2_read || l2_write) begin
                    op_write_d = l2_write;
                    addr_d     = line_align(l2_address);
                    wline_d    = l2_wdata;
                    cnt_clear  = 1'b1;
                    state_d    = BURST;
                end
            end
            BURST: begin
                mem_read  = !op_write_q;
                mem_write = op_write_q;
                if (mem_resp) begin
                    cnt_incr = 1'b1;
                    if (!op_write_q) begin
                        for (int b = 0; b < NBEATS; b++) begin
                            if (cnt == CNT_W'(b)) begin
                                rdata_d[b*BEAT_W +: BEAT_W] = mem_rdata;
                            end
                        end
                    end
                    if (cnt_last) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                l2_resp = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                // The arbiter drops its request a cycle late; wait for it so
                // the stale level cannot launch a second burst.
                if (!l2_read && !l2_write) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and line registers; reset clears everything so all outputs drop at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wline_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wline_q    <= wline_d;
            rdata_q    <= rdata_d;
        end
    end

    assign l2_rdata = rdata_q;

endmodule

// File: doc/l2_burst_responder.md
# l2_burst_responder

Responder on the L2 side of the line-granularity request interface that the L1 cache arbiter drives. It accepts one 128-bit line read or write at a time and serialises it into a 4-beat burst on a 32-bit physical-memory port. For reads it reassembles the beats into a line; for writes it slices the latched line into beats. It then returns a single-cycle `l2_resp`. It sits between the arbiter's `l2cache_*` port and main memory, and presents to the arbiter exactly as an L2 cache does.

## Interface
Parameters:
- `LINE_W`, 128, line width in bits; must equal the width of `lc3b_l1_line`.
- `BEAT_W`, 32, memory beat width. `LINE_W / BEAT_W` gives the beat count `NBEATS` (4) and must be a power of 2.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `l2_address`  in  16  line request address (`lc3b_word`).
- `l2_read`  in  1  read request, level, held until resp seen.
- `l2_write`  in  1  write request, level, held until resp seen.
- `l2_wdata`  in  LINE_W  write line; sampled at acceptance.
- `l2_rdata`  out  LINE_W  assembled read line; registered.
- `l2_resp`  out  1  one-cycle completion pulse.
- `mem_address`  out  16  line-aligned burst address; bits [3:0] are always 0.
- `mem_read`  out  1  burst read, held for the whole burst.
- `mem_write`  out  1  burst write, held for the whole burst.
- `mem_wdata`  out  BEAT_W  current write beat.
- `mem_rdata`  in  BEAT_W  read beat; valid when `mem_resp` is high.
- `mem_resp`  in  1  one beat completes on each cycle it is high.

## Operation
States: IDLE, BURST, RESP, DRAIN.

- **IDLE**
  - If `l2_read` or `l2_write` is high:
    - latch the operation, `{l2_address[15:4], 4'h0}` and `l2_wdata`;
    - clear the beat counter;
    - go to BURST.
  - If both requests are high, the write wins.
- **BURST**
  - `mem_read` or `mem_write` is held high for the latched operation.
  - `mem_address` is the latched aligned address.
  - `mem_wdata` = latched line bits `[cnt*BEAT_W +: BEAT_W]`.
  - On each `mem_resp`:
    - read: store `mem_rdata` into `l2_rdata[cnt*BEAT_W +: BEAT_W]`;
    - increment `cnt`.
  - When `mem_resp` is high and `cnt == NBEATS-1`, go to RESP.
  - Beat 0 occupies the LSBs of the line.
- **RESP**
  - `l2_resp` = 1 for exactly this cycle.
  - Memory strobes are low.
  - Next state is DRAIN.
- **DRAIN**
  - Wait until `l2_read` and `l2_write` are both low, then go to IDLE.
  - This stops the arbiter's delayed request deassert from launching a duplicate burst.
- Boundary rules:
  - `mem_resp` outside BURST is ignored.
  - Changes on `l2_address` or `l2_wdata` after acceptance are ignored.
  - The counter is 2 bits and only wraps at the BURST→RESP exit.
  - `l2_rdata` holds its value until overwritten by a later read burst; a write leaves it unchanged.
- Reset (at any time, including mid-burst):
  - state goes to IDLE, counter to 0;
  - all outputs go to 0, including `l2_rdata`, `mem_address` and `mem_wdata`;
  - outputs drop asynchronously.
  - An aborted burst produces no `l2_resp`.

## Timing
- The request is sampled in IDLE at edge t. `mem_read`/`mem_write` are high from cycle t+1.
- With zero-wait memory (`mem_resp` high every BURST cycle), beats land at t+1..t+4 and `l2_resp` is high in cycle t+5.
  - This is the minimum latency: 5 cycles.
- Each memory wait cycle adds one cycle.
- `l2_rdata` is stable and complete in the cycle `l2_resp` is high, and remains stable afterwards.
- Minimum spacing from one `l2_resp` to the next request's acceptance: 2 cycles (RESP → DRAIN, where requests must be seen low → IDLE).
- No combinational path from any input to any output.

## Structure
- Shared package `lc3b_types`:
  - reuse `lc3b_word` and `lc3b_l1_line`;
  - add `lc3b_mem_beat` (logic [31:0]);
  - add enum `l2_burst_state_t` {IDLE, BURST, RESP, DRAIN}.
- One natural sub-module, `burst_beat_counter`:
  - inputs: clear, increment on `mem_resp`;
  - outputs: `cnt` and `last`;
  - asynchronous active-low reset.
- FSM and line registers live in the top module.

## Test plan
- **Reset:** hold `reset_n` = 0 → all outputs 0 and state IDLE. Release with `l2_read` = 0 → `mem_read` stays 0.
- **Zero-wait read:** `l2_read` = 1 at 0x1234, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - `mem_address` = 0x1230.
  - `l2_rdata` = 0x44444444_33333333_22222222_11111111.
  - `l2_resp` pulses once, 5 cycles after acceptance.
- **Write with waits:** `l2_write` = 1 at 0x00F8, `l2_wdata` = 0xDDDD..._CCCC..._BBBB..._AAAA..., and `mem_resp` low 2 cycles before each beat.
  - `mem_wdata` sequence is 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD.
  - `mem_address` = 0x00F0.
  - `l2_resp` arrives at cycle 13.
  - `l2_rdata` unchanged.
- **Drain:** hold `l2_read` high 3 cycles past `l2_resp` → no second burst. Drop it, then assert `l2_read` at 0x2000 → a new burst starts 1 cycle after the request is seen in IDLE.
- **Reset mid-burst:** pull `reset_n` low after beat 2 of a read.
  - `mem_read` drops immediately; no `l2_resp`; `l2_rdata` = 0.
  - A following read assembles a fresh, correct line.
- **Simultaneous request:** `l2_read` and `l2_write` both high → write burst is performed and `mem_read` never asserts.
